// File: rtl/bp_fe_npc_gen.sv
// Next-PC generator: one-outstanding fetch sequencer with redirect, RAS and PC+4 selection.
// Optional RAS steering is enabled by defining BP_FE_NPC_GEN_RAS_EN.
module bp_fe_npc_gen #(
  parameter int unsigned                eaddr_width_p = 32,
  parameter int unsigned                instr_width_p = 32,
  parameter logic [eaddr_width_p-1:0]   reset_pc_p    = '0
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      redirect_v_i,
  input  logic [eaddr_width_p-1:0]  redirect_pc_i,
  output logic [eaddr_width_p-1:0]  fetch_pc_o,
  output logic                      fetch_pc_v_o,
  input  logic                      fetch_ready_i,
  input  logic                      fetch_v_i,
  input  logic [instr_width_p-1:0]  fetch_instr_i,
  output logic                      instr_v_o,
  output logic [instr_width_p-1:0]  instr_o,
  output logic [eaddr_width_p-1:0]  instr_pc_o,
  input  logic [eaddr_width_p-1:0]  ras_pc_i,
  input  logic                      ras_v_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

  state_e                    state_q, state_n;
  logic [eaddr_width_p-1:0]  pc_q, pc_n;
  logic [eaddr_width_p-1:0]  inflight_pc_q, inflight_pc_n;
  logic [eaddr_width_p-1:0]  resp_next_pc;

  // PC to fetch after a delivered instruction; redirects are handled in the FSM
`ifdef BP_FE_NPC_GEN_RAS_EN
  assign resp_next_pc = ras_v_i ? ras_pc_i : inflight_pc_q + eaddr_width_p'(4);
`else
  logic unused_ras;
  assign unused_ras   = ^{ras_v_i, ras_pc_i};
  assign resp_next_pc = inflight_pc_q + eaddr_width_p'(4);
`endif

  assign fetch_pc_o = pc_q;
  assign instr_o    = fetch_instr_i;
  assign instr_pc_o = inflight_pc_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      pc_q          <= reset_pc_p;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_n;
      pc_q          <= pc_n;
      inflight_pc_q <= inflight_pc_n;
    end
  end

  always_comb begin
    state_n       = state_q;
    pc_n          = pc_q;
    inflight_pc_n = inflight_pc_q;
    fetch_pc_v_o  = 1'b0;
    instr_v_o     = 1'b0;

    case (state_q)
      IDLE: begin
        state_n = REQ;
        if (redirect_v_i) pc_n = redirect_pc_i;
      end
      REQ: begin
        fetch_pc_v_o = ~redirect_v_i;
        if (redirect_v_i) begin
          pc_n = redirect_pc_i;
        end else if (fetch_ready_i) begin
          inflight_pc_n = pc_q;
          state_n       = WAIT;
        end
      end
      WAIT: begin
        instr_v_o = fetch_v_i & ~redirect_v_i;
        if (redirect_v_i) begin
          pc_n    = redirect_pc_i;
          state_n = fetch_v_i ? REQ : DROP;
        end else if (fetch_v_i) begin
          pc_n    = resp_next_pc;
          state_n = REQ;
        end
      end
      DROP: begin
        // Outstanding response is discarded on arrival; latest redirect wins
        if (redirect_v_i) pc_n = redirect_pc_i;
        if (fetch_v_i)    state_n = REQ;
      end
      default: state_n = IDLE;
    endcase

    if (reset_i) begin
      fetch_pc_v_o = 1'b0;
      instr_v_o    = 1'b0;
    end
  end

endmodule

// File: tb/tb_bp_fe_npc_gen.sv
// Scoreboard bench for bp_fe_npc_gen: a transaction-level model predicts per-cycle outputs.
module tb_bp_fe_npc_gen;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        reset_i;
  logic        redirect_v_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] fetch_pc_o;
  logic        fetch_pc_v_o;
  logic        fetch_ready_i;
  logic        fetch_v_i;
  logic [31:0] fetch_instr_i;
  logic        instr_v_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [31:0] ras_pc_i;
  logic        ras_v_i;

  bp_fe_npc_gen #(
    .eaddr_width_p(32),
    .instr_width_p(32),
    .reset_pc_p   (RST_PC)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .redirect_v_i (redirect_v_i),
    .redirect_pc_i(redirect_pc_i),
    .fetch_pc_o   (fetch_pc_o),
    .fetch_pc_v_o (fetch_pc_v_o),
    .fetch_ready_i(fetch_ready_i),
    .fetch_v_i    (fetch_v_i),
    .fetch_instr_i(fetch_instr_i),
    .instr_v_o    (instr_v_o),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .ras_pc_i     (ras_pc_i),
    .ras_v_i      (ras_v_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        fv;
    logic [31:0] fpc;
    logic        iv;
    logic [31:0] ins;
    logic [31:0] ipc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: fetch is either starting up, free to issue, awaiting a
  // response it will deliver, or awaiting a response it will throw away.
  bit          m_known   = 1'b0;
  bit          m_startup = 1'b1;
  bit          m_pending = 1'b0;
  bit          m_discard = 1'b0;
  logic [31:0] m_next_pc;
  logic [31:0] m_last_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy,
                     input bit fv, input logic [31:0] ins, input bit rasv, input logic [31:0] raspc);
    bit issue, deliver;
    @(negedge clk);
    reset_i       = rst;
    redirect_v_i  = rv;
    redirect_pc_i = rpc;
    fetch_ready_i = rdy;
    fetch_v_i     = fv;
    fetch_instr_i = ins;
    ras_v_i       = rasv;
    ras_pc_i      = raspc;

    issue   = !rst && !m_startup && !m_pending && !rv;
    deliver = !rst && m_pending && !m_discard && fv && !rv;
    if (m_known)
      exp_q.push_back('{fv: issue, fpc: m_next_pc, iv: deliver, ins: ins, ipc: m_last_pc});

    if (rst) begin
      m_known   = 1'b1;
      m_startup = 1'b1;
      m_pending = 1'b0;
      m_discard = 1'b0;
      m_next_pc = RST_PC;
      m_last_pc = 32'h0;
    end else if (m_startup) begin
      m_startup = 1'b0;
      if (rv) m_next_pc = rpc;
    end else if (!m_pending) begin
      if (rv) m_next_pc = rpc;
      else if (rdy) begin
        m_last_pc = m_next_pc;
        m_pending = 1'b1;
      end
    end else begin
      if (rv) begin
        m_next_pc = rpc;
        if (!fv) m_discard = 1'b1;
      end else if (fv && !m_discard) begin
`ifdef BP_FE_NPC_GEN_RAS_EN
        m_next_pc = rasv ? raspc : m_last_pc + 32'd4;
`else
        m_next_pc = m_last_pc + 32'd4;
`endif
      end
      if (fv) begin
        m_pending = 1'b0;
        m_discard = 1'b0;
      end
    end
  endtask

  // Monitor: compares DUT outputs against the oldest prediction each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fetch_pc_v", 32'(fetch_pc_v_o), 32'(e.fv));
        chk("fetch_pc",   fetch_pc_o,        e.fpc);
        chk("instr_v",    32'(instr_v_o),    32'(e.iv));
        chk("instr_pc",   instr_pc_o,        e.ipc);
        if (e.iv) chk("instr", instr_o, e.ins);
      end
    end
  end

  initial begin
    logic [31:0] rpc;
    reset_i = 1'b1; redirect_v_i = 1'b0; redirect_pc_i = '0; fetch_ready_i = 1'b0;
    fetch_v_i = 1'b0; fetch_instr_i = '0; ras_v_i = 1'b0; ras_pc_i = '0;

    // reset, start-up, first fetch at reset PC, sequential next
    cyc(1, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 32'h13, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h13, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h0000_0013, 0, 0);
    // back-pressure: three stalled cycles then one accept
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'hdead, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h0000_0093, 0, 0);
    // redirect in REQ to 0x200, return instruction with RAS hint
    cyc(0, 1, 32'h200, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h0000_8067, 1, 32'h340);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    // redirect while waiting: late response dropped, fetch 0x800
    cyc(0, 1, 32'h800, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h1111, 1, 32'h500);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    // redirect coincident with response beats RAS
    cyc(0, 1, 32'h900, 1, 1, 32'h2222, 1, 32'h600);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h3333, 0, 0);
    // PC+4 wrap at top of address space
    cyc(0, 1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h4444, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    // reset in the middle of an outstanding request
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h5555, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h6666, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 9) == 0, rpc,
          $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, $urandom(),
          $urandom_range(0, 1) == 1, $urandom() & 32'hFFFF_FFFC);
    end

    @(negedge clk);
    @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_fe_npc_gen.md
BP_FE_NPC_GEN -- requirements
Module: bp_fe_npc_gen

Interface
REQ-001 SHALL have parameter eaddr_width_p, default 32, effective address width.
REQ-002 SHALL have parameter instr_width_p, default 32, instruction width.
REQ-003 SHALL have parameter reset_pc_p, default 0, first fetch PC after reset.
REQ-004 SHALL have port clk_i  input  1  clock; one clock, all state on rising edge.
REQ-005 SHALL have port reset_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port redirect_v_i  input  1  backend redirect valid (mispredict/exception).
REQ-007 SHALL have port redirect_pc_i  input  eaddr_width_p  redirect target PC.
REQ-008 SHALL have port fetch_pc_o  output  eaddr_width_p  PC presented to I-cache.
REQ-009 SHALL have port fetch_pc_v_o  output  1  fetch request valid.
REQ-010 SHALL have port fetch_ready_i  input  1  I-cache accepts request when high with fetch_pc_v_o.
REQ-011 SHALL have port fetch_v_i  input  1  I-cache response valid.
REQ-012 SHALL have port fetch_instr_i  input  instr_width_p  I-cache response instruction.
REQ-013 SHALL have port instr_v_o  output  1  instruction valid to RAS/decode.
REQ-014 SHALL have port instr_o  output  instr_width_p  instruction to RAS instr_i.
REQ-015 SHALL have port instr_pc_o  output  eaddr_width_p  PC of instr_o, to RAS pc_i.
REQ-016 SHALL have port ras_pc_i  input  eaddr_width_p  RAS return-address prediction.
REQ-017 SHALL have port ras_v_i  input  1  RAS prediction valid.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, WAIT, DROP; at most one request outstanding.
REQ-019 SHALL hold registers pc_q (next fetch PC) and inflight_pc_q (PC of accepted request).
REQ-020 IDLE: fetch_pc_v_o=0; unconditionally -> REQ next cycle (redirect in IDLE loads pc_q).
REQ-021 REQ: fetch_pc_o=pc_q; fetch_pc_v_o = ~redirect_v_i; accept = fetch_pc_v_o & fetch_ready_i.
REQ-022 REQ on accept: inflight_pc_q<=pc_q, -> WAIT; no accept: stay REQ, pc_q held.
REQ-023 REQ with redirect_v_i: pc_q<=redirect_pc_i, stay REQ, no request issued that cycle.
REQ-024 WAIT: fetch_pc_v_o=0; instr_v_o = fetch_v_i & ~redirect_v_i, combinational (zero latency).
REQ-025 instr_o=fetch_instr_i, instr_pc_o=inflight_pc_q whenever state is WAIT.
REQ-026 WAIT on instr_v_o: pc_q<=ras_pc_i if ras_v_i, else inflight_pc_q+4 modulo 2^eaddr_width_p; -> REQ.
REQ-027 WAIT with redirect_v_i & fetch_v_i: response discarded, pc_q<=redirect_pc_i, -> REQ.
REQ-028 WAIT with redirect_v_i & ~fetch_v_i: pc_q<=redirect_pc_i, -> DROP.
REQ-029 DROP: fetch_pc_v_o=0, instr_v_o=0; fetch_v_i -> REQ; redirect_v_i loads pc_q (last redirect wins).
REQ-030 Redirect SHALL have priority over RAS prediction, RAS over sequential PC+4.
REQ-031 ras_v_i/ras_pc_i SHALL be ignored in any cycle instr_v_o=0.
REQ-032 fetch_v_i in IDLE or REQ SHALL be ignored (no state change, instr_v_o=0).
REQ-033 PC+4 wrap: 0xFFFF_FFFC+4 SHALL yield 0x0000_0000 (eaddr_width_p=32).

Reset
REQ-034 On reset_i high at clk edge: state<=IDLE, pc_q<=reset_pc_p, inflight_pc_q<=0.
REQ-035 During/after reset: fetch_pc_v_o=0, instr_v_o=0, fetch_pc_o=reset_pc_p, instr_pc_o=0.
REQ-036 Reset mid-request (WAIT/DROP) SHALL abandon the outstanding response; a late fetch_v_i in IDLE/REQ is ignored per REQ-032.

Configuration
REQ-037 Macro BP_FE_NPC_GEN_RAS_EN defined: REQ-026 RAS selection active.
REQ-038 Macro undefined: ras_pc_i/ras_v_i unused, next PC after response always inflight_pc_q+4; ports retained.

Verification
REQ-039 Reset, reset_pc_p=0x100, ready=1 -> cycle after reset IDLE, then fetch_pc_o=0x100 valid, response -> next request 0x104.
REQ-040 Response instr=0x00008067 at pc 0x200 with ras_v_i=1, ras_pc_i=0x340 -> instr_v_o=1, instr_pc_o=0x200, next fetch_pc_o=0x340 (0x204 with macro undefined).
REQ-041 fetch_ready_i=0 for 3 cycles in REQ -> fetch_pc_v_o held 1, fetch_pc_o stable 0x104, single accept on 4th cycle.
REQ-042 Redirect to 0x800 in WAIT before response -> DROP; response arrives -> instr_v_o=0; next fetch_pc_o=0x800.
REQ-043 Redirect 0x900 coincident with fetch_v_i in WAIT, ras_v_i=1 -> instr_v_o=0, next fetch_pc_o=0x900.
REQ-044 inflight_pc 0xFFFF_FFFC response, ras_v_i=0 -> next fetch_pc_o=0x0000_0000.
